// File: rtl/dmem_arbiter_pkg.sv
// Shared DataMem constants and the arbiter state encoding, used by the
// processor, the DataMem wrapper and the arbiter.
package dmem_arbiter_pkg;

    localparam int DM_AW = 10;
    localparam int DM_DW = 16;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Round-robin picker: the first requester after `last` (wrapping modulo NREQ)
// whose request is high. `last` itself has the lowest priority.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   sel,
    output logic            any
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Scan from the furthest candidate (last itself) down to the nearest
    // (last+1). The nearest requesting index is written last, so it wins.
    always_comb begin
        sel = '0;
        any = 1'b0;
        sum = '0;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            sum = {1'b0, last} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            idx = sum[IW-1:0];
            if (req[idx]) begin
                sel = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single DataMem read/write port pair among NREQ requesters with
// round-robin fairness. Each access is a fixed IDLE -> ACCESS -> DONE
// sequence; every output is a flop.
//
// Handshake: a requester raises req[i] with we/addr/wdata valid and holds it
// until ack[i]. Those inputs are only sampled in IDLE. ack[i] is a 1-cycle
// pulse in DONE (rdata valid then for reads); the requester drops req[i] in
// the following cycle, otherwise it is arbitrated again as a fresh access.
// Dropping req early does not cancel an access already granted.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = DM_AW,
    parameter int DW   = DM_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [DW-1:0]     rdata,
    output logic              busy,
    output logic [AW-1:0]     dm_wr_addr,
    output logic [DW-1:0]     dm_wr_dat,
    output logic              dm_write,
    output logic [AW-1:0]     dm_rd_addr,
    input  logic [DW-1:0]     dm_rd_dat
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [IW-1:0] last_q, last_d;
    logic          we_q, we_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] dm_wr_addr_q, dm_wr_addr_d;
    logic [DW-1:0] dm_wr_dat_q, dm_wr_dat_d;
    logic          dm_write_q, dm_write_d;
    logic [AW-1:0] dm_rd_addr_q, dm_rd_addr_d;

    logic [IW-1:0] pick_sel;
    logic          pick_any;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req  (req),
        .last (last_q),
        .sel  (pick_sel),
        .any  (pick_any)
    );

    // Next-state and next-output logic. Outputs for a state are computed on
    // the edge entering it, so gnt/dm_* are already valid during ACCESS and
    // ack during DONE.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_d       = last_q;
        we_d         = we_q;
        gnt_d        = '0;
        ack_d        = '0;
        busy_d       = 1'b0;
        rdata_d      = rdata_q;
        dm_wr_addr_d = dm_wr_addr_q;
        dm_wr_dat_d  = dm_wr_dat_q;
        dm_write_d   = 1'b0;
        dm_rd_addr_d = dm_rd_addr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    sel_d           = pick_sel;
                    last_d          = pick_sel;
                    we_d            = we[pick_sel];
                    gnt_d[pick_sel] = 1'b1;
                    busy_d          = 1'b1;
                    if (we[pick_sel]) begin
                        dm_wr_addr_d = addr[int'(pick_sel)*AW +: AW];
                        dm_wr_dat_d  = wdata[int'(pick_sel)*DW +: DW];
                        dm_write_d   = 1'b1;
                    end else begin
                        dm_rd_addr_d = addr[int'(pick_sel)*AW +: AW];
                    end
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                // DataMem read is combinational from dm_rd_addr_q.
                if (!we_q) begin
                    rdata_d = dm_rd_dat;
                end
                ack_d[sel_q] = 1'b1;
                busy_d       = 1'b1;
                state_d      = ARB_DONE;
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            sel_q        <= '0;
            last_q       <= IW'(NREQ - 1);
            we_q         <= 1'b0;
            gnt_q        <= '0;
            ack_q        <= '0;
            busy_q       <= 1'b0;
            rdata_q      <= '0;
            dm_wr_addr_q <= '0;
            dm_wr_dat_q  <= '0;
            dm_write_q   <= 1'b0;
            dm_rd_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            we_q         <= we_d;
            gnt_q        <= gnt_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            rdata_q      <= rdata_d;
            dm_wr_addr_q <= dm_wr_addr_d;
            dm_wr_dat_q  <= dm_wr_dat_d;
            dm_write_q   <= dm_write_d;
            dm_rd_addr_q <= dm_rd_addr_d;
        end
    end

    assign gnt        = gnt_q;
    assign ack        = ack_q;
    assign busy       = busy_q;
    assign rdata      = rdata_q;
    assign dm_wr_addr = dm_wr_addr_q;
    assign dm_wr_dat  = dm_wr_dat_q;
    assign dm_write   = dm_write_q;
    assign dm_rd_addr = dm_rd_addr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with four requesters and a small
// behavioural DataMem (registered write, combinational read).
module tb_dmem_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 10;
    localparam int DW   = 16;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic [AW-1:0]     dm_wr_addr;
    logic [DW-1:0]     dm_wr_dat;
    logic              dm_write;
    logic [AW-1:0]     dm_rd_addr;
    logic [DW-1:0]     dm_rd_dat;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .gnt        (gnt),
        .ack        (ack),
        .rdata      (rdata),
        .busy       (busy),
        .dm_wr_addr (dm_wr_addr),
        .dm_wr_dat  (dm_wr_dat),
        .dm_write   (dm_write),
        .dm_rd_addr (dm_rd_addr),
        .dm_rd_dat  (dm_rd_dat)
    );

    // clock / datamem model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dm_write) mem[dm_wr_addr] <= dm_wr_dat;
    end
    assign dm_rd_dat = mem[dm_rd_addr];

    // checker
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[i]             = w;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".gnt"}, 32'(gnt), 32'h0);
        check({tag, ".ack"}, 32'(ack), 32'h0);
        check({tag, ".busy"}, 32'(busy), 32'h0);
        check({tag, ".dm_write"}, 32'(dm_write), 32'h0);
    endtask

    localparam logic [3:0] RR_GNT [0:3] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[9] = 16'hBEEF;
        rst   = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;

        // 1: reset with no requests
        for (int c = 0; c < 2; c++) begin
            tick();
            check_idle("rst");
            check("rst.rdata", 32'(rdata), 32'h0);
            check("rst.dm_wr_addr", 32'(dm_wr_addr), 32'h0);
        end
        rst = 1'b0;

        // 2: write from requester 0, read back through requester 1
        set_port(0, 1'b1, 10'd5, 16'h1234);
        req = 4'b0001;
        tick();
        check("wr.gnt", 32'(gnt), 32'h1);
        check("wr.dm_write", 32'(dm_write), 32'h1);
        check("wr.dm_wr_addr", 32'(dm_wr_addr), 32'd5);
        check("wr.dm_wr_dat", 32'(dm_wr_dat), 32'h1234);
        check("wr.busy", 32'(busy), 32'h1);
        check("wr.ack_early", 32'(ack), 32'h0);
        tick();
        check("wr.ack", 32'(ack), 32'h1);
        check("wr.done_gnt", 32'(gnt), 32'h0);
        check("wr.done_dm_write", 32'(dm_write), 32'h0);
        check("wr.done_busy", 32'(busy), 32'h1);
        req = '0;
        tick();
        check_idle("wr.idle");
        set_port(1, 1'b0, 10'd5, 16'h0);
        req = 4'b0010;
        tick();
        check("rd.gnt", 32'(gnt), 32'h2);
        check("rd.dm_rd_addr", 32'(dm_rd_addr), 32'd5);
        check("rd.dm_write", 32'(dm_write), 32'h0);
        tick();
        check("rd.ack", 32'(ack), 32'h2);
        check("rd.rdata", 32'(rdata), 32'h1234);
        req = '0;
        tick();
        check_idle("rd.idle");

        // 3: two requesters held high alternate after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_port(0, 1'b0, 10'd5, 16'h0);
        set_port(1, 1'b0, 10'd5, 16'h0);
        req = 4'b0011;
        for (int r = 0; r < 4; r++) begin
            tick();
            check($sformatf("rr%0d.gnt", r), 32'(gnt), 32'(RR_GNT[r]));
            tick();
            check($sformatf("rr%0d.ack", r), 32'(ack), 32'(RR_GNT[r]));
            check($sformatf("rr%0d.rdata", r), 32'(rdata), 32'h1234);
            tick();
            check($sformatf("rr%0d.busy", r), 32'(busy), 32'h0);
        end

        // 4: last=1, requesters 3 and 1 -> 3 first, then 1
        set_port(3, 1'b0, 10'd9, 16'h0);
        req = 4'b1010;
        tick();
        check("p4a.gnt", 32'(gnt), 32'h8);
        tick();
        check("p4a.ack", 32'(ack), 32'h8);
        check("p4a.rdata", 32'(rdata), 32'hBEEF);
        tick();
        tick();
        check("p4b.gnt", 32'(gnt), 32'h2);
        tick();
        check("p4b.ack", 32'(ack), 32'h2);
        check("p4b.rdata", 32'(rdata), 32'h1234);
        req = '0;
        tick();
        check_idle("p4.idle");

        // 5: reset during a write access aborts it
        set_port(2, 1'b1, 10'd7, 16'h5555);
        req = 4'b0100;
        tick();
        check("ab.gnt", 32'(gnt), 32'h4);
        check("ab.dm_write", 32'(dm_write), 32'h1);
        rst = 1'b1;
        req = '0;
        tick();
        check_idle("ab.rst");
        rst = 1'b0;
        set_port(0, 1'b0, 10'd5, 16'h0);
        req = 4'b1001;
        tick();
        check("ab.next_gnt", 32'(gnt), 32'h1);
        check("ab.no_ack", 32'(ack), 32'h0);
        tick();
        check("ab.next_ack", 32'(ack), 32'h1);
        req = '0;
        tick();

        // 6: requester drops req during ACCESS of a read
        set_port(0, 1'b0, 10'd9, 16'h0);
        req = 4'b0001;
        tick();
        check("drop.gnt", 32'(gnt), 32'h1);
        check("drop.dm_rd_addr", 32'(dm_rd_addr), 32'd9);
        req = '0;
        set_port(0, 1'b0, 10'd5, 16'h0);
        tick();
        check("drop.ack", 32'(ack), 32'h1);
        check("drop.rdata", 32'(rdata), 32'hBEEF);
        tick();
        check_idle("drop.idle");
        check("drop.rdata_hold", 32'(rdata), 32'hBEEF);

        // report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
